// File: rtl/jk_bank_pkg.sv
// Shared mode and state encodings for the J-K bank driver.
package jk_bank_pkg;

    localparam logic [1:0] JK_MODE_SET    = 2'b00;
    localparam logic [1:0] JK_MODE_TOGGLE = 2'b01;
    localparam logic [1:0] JK_MODE_CLEAR  = 2'b10;
    localparam logic [1:0] JK_MODE_HOLD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/jk_excite.sv
// Combinational word map from (mode, bank Q, target) to J/K excitation,
// bank clear, and the bank value expected once the excitation has landed.
module jk_excite
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             clr,
    output logic [WIDTH-1:0] expected
);

    always_comb begin
        j        = '0;
        k        = '0;
        clr      = 1'b0;
        expected = tgt;
        case (mode)
            JK_MODE_SET: begin
                j = tgt;
                k = ~tgt;
            end
            JK_MODE_TOGGLE: begin
                // toggle only the bits that differ from the target
                j = q ^ tgt;
                k = q ^ tgt;
            end
            JK_MODE_CLEAR: begin
                clr      = 1'b1;
                expected = '0;
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Request-driven sequencer that excites a J-K bank for one cycle per attempt.
// Readback and retry are built only when JK_BANK_VERIFY_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request
// DRIVE  | J/K or bank clear applied for one cycle
// SETTLE | bank has sampled, allow Q to settle
// CHECK  | compare readback with expected, retry or finish
// DONE   | one-cycle completion pulse
module jk_bank_driver
    import jk_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [1:0]       tgt_mode,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             bank_clr,
    output logic             done_valid,
    output logic             done_err,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_q;
    logic [1:0]       mode_q;
    logic             accept;
    logic [WIDTH-1:0] ex_j;
    logic [WIDTH-1:0] ex_k;
    logic             ex_clr;
    logic [WIDTH-1:0] ex_exp;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .mode     (mode_q),
        .q        (q_fb),
        .tgt      (tgt_q),
        .j        (ex_j),
        .k        (ex_k),
        .clr      (ex_clr),
        .expected (ex_exp)
    );

    assign accept = tgt_valid && tgt_ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= ST_IDLE;
            tgt_q  <= '0;
            mode_q <= JK_MODE_SET;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tgt_q  <= tgt_data;
                mode_q <= tgt_mode;
            end
        end
    end

`ifdef JK_BANK_VERIFY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RW-1:0] retry_cnt;
    logic          retry_inc;
    logic          mismatch;
    logic          err_q;

    assign mismatch = (q_fb != ex_exp);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            retry_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept)
                retry_cnt <= '0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + RW'(1);
            // the last CHECK before DONE leaves the final verdict here
            if (accept)
                err_q <= 1'b0;
            else if (state == ST_CHECK)
                err_q <= mismatch;
        end
    end

    assign done_err = done_valid & err_q;
`else
    logic unused_expected;
    assign unused_expected = ^ex_exp;
    assign done_err        = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        tgt_ready  = 1'b0;
        busy       = 1'b1;
        j          = '0;
        k          = '0;
        bank_clr   = 1'b0;
        done_valid = 1'b0;
`ifdef JK_BANK_VERIFY_EN
        retry_inc  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                tgt_ready = 1'b1;
                busy      = 1'b0;
                if (tgt_valid)
                    state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                j        = ex_j;
                k        = ex_k;
                bank_clr = ex_clr;
`ifdef JK_BANK_VERIFY_EN
                state_nxt = ST_SETTLE;
`else
                state_nxt = ST_DONE;
`endif
            end
`ifdef JK_BANK_VERIFY_EN
            ST_SETTLE: state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (mismatch && (retry_cnt < RW'(MAX_RETRY))) begin
                    retry_inc = 1'b1;
                    state_nxt = ST_DRIVE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
